// File: rtl/fetch_if.sv
// Fetch unit bus bundle: PC-counter control, instruction memory read port and
// decode-side instruction handshake.
//   master : the fetch unit (drives PC requests, memory reads, instructions)
//   slave  : the environment (PC counter, instruction memory, decode, branch unit)
interface fetch_if;
    localparam int unsigned XLEN = 32;

    // PC counter
    logic [XLEN-1:0] pc_in;
    logic            pc_increment;
    logic            pc_load;
    logic [XLEN-1:0] pc_step;
    logic [XLEN-1:0] pc_load_value;

    // Branch/jump redirect
    logic            redirect;
    logic [XLEN-1:0] redirect_target;

    // Instruction memory
    logic            mem_read;
    logic [XLEN-1:0] mem_addr;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;

    // Decode handshake
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr_out;
    logic [XLEN-1:0] instr_pc;

    modport master (
        input  pc_in, redirect, redirect_target, mem_ready, mem_rdata, instr_ready,
        output pc_increment, pc_load, pc_step, pc_load_value,
        output mem_read, mem_addr, instr_valid, instr_out, instr_pc
    );

    modport slave (
        output pc_in, redirect, redirect_target, mem_ready, mem_rdata, instr_ready,
        input  pc_increment, pc_load, pc_step, pc_load_value,
        input  mem_read, mem_addr, instr_valid, instr_out, instr_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit. Requests the word at pc_in, hands it to decode with a
// valid/ready handshake and steps the external PC counter once per fetched
// instruction. A redirect reloads the PC; a read that is still in flight when
// a redirect arrives is drained (address held) and its data dropped.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - fetch_if.master: PC control, memory read port, decode handshake
module fetch_unit #(
    parameter int unsigned STEP = 4
) (
    input  logic    clk,
    input  logic    rst,
    fetch_if.master bus
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        VALID = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] instr_out_q, instr_out_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic [XLEN-1:0] drain_addr_q, drain_addr_d;

    logic            mem_read_c;
    logic [XLEN-1:0] mem_addr_c;
    logic            pc_increment_c;
    logic            pc_load_c;

    // State and captured instruction registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            instr_out_q  <= '0;
            instr_pc_q   <= '0;
            drain_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            instr_out_q  <= instr_out_d;
            instr_pc_q   <= instr_pc_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    // Next state and combinational strobes
    always_comb begin
        state_d        = state_q;
        instr_out_d    = instr_out_q;
        instr_pc_d     = instr_pc_q;
        drain_addr_d   = drain_addr_q;
        mem_read_c     = 1'b0;
        mem_addr_c     = '0;
        pc_increment_c = 1'b0;
        // Redirect reloads the PC from any state; gated so reset holds it low
        pc_load_c      = bus.redirect & rst;

        case (state_q)
            IDLE: state_d = REQ;

            REQ: begin
                mem_read_c = 1'b1;
                mem_addr_c = bus.pc_in;
                if (bus.redirect) begin
                    // In-flight read must complete at its original address
                    if (!bus.mem_ready) begin
                        drain_addr_d = bus.pc_in;
                        state_d      = DRAIN;
                    end
                end else if (bus.mem_ready) begin
                    instr_out_d    = bus.mem_rdata;
                    instr_pc_d     = bus.pc_in;
                    pc_increment_c = 1'b1;
                    state_d        = VALID;
                end
            end

            DRAIN: begin
                mem_read_c = 1'b1;
                mem_addr_c = drain_addr_q;
                if (bus.mem_ready) begin
                    state_d = REQ;
                end
            end

            VALID: begin
                if (bus.redirect || bus.instr_ready) begin
                    state_d = REQ;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_read      = mem_read_c;
    assign bus.mem_addr      = mem_addr_c;
    assign bus.pc_increment  = pc_increment_c;
    assign bus.pc_load       = pc_load_c;
    assign bus.pc_load_value = bus.redirect_target;
    assign bus.pc_step       = XLEN'(STEP);
    assign bus.instr_valid   = (state_q == VALID);
    assign bus.instr_out     = instr_out_q;
    assign bus.instr_pc      = instr_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random traffic, all
// checked against a transaction-level model of the fetch stream and PC counter.
module tb_fetch_unit;
    localparam int unsigned STEP = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fetch_if bus ();

    fetch_unit #(.STEP(STEP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] pc;          // external PC counter value
    logic [31:0] exp_pc;      // address of next instruction decode must receive
    logic [31:0] cur_ipc;     // instruction register contents
    logic [31:0] cur_out;
    logic [31:0] stale_addr;  // address of a redirected read still outstanding
    bit          stale;
    bit          just_reset;
    bit          prev_inc;
    bit          prev_hold;

    // Last sampled outputs for directed checks
    logic        last_mread;
    logic [31:0] last_addr;
    logic        last_valid;
    logic        last_inc;
    logic [31:0] last_ipc;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst                 = 1'b0;
        bus.redirect        = 1'b0;
        bus.redirect_target = '0;
        bus.mem_ready       = 1'b0;
        bus.instr_ready     = 1'b0;
        bus.mem_rdata       = '0;
        pc                  = '0;
        bus.pc_in           = '0;
        exp_pc              = '0;
        cur_ipc             = '0;
        cur_out             = '0;
        stale               = 1'b0;
        stale_addr          = '0;
        just_reset          = 1'b1;
        prev_inc            = 1'b0;
        prev_hold           = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_mread", 32'(bus.mem_read), 32'd0);
        chk("rst_out", bus.instr_out, 32'd0);
        rst = 1'b1;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance
    task automatic cycle(input bit rd, input logic [31:0] tgt, input bit mrdy, input bit irdy);
        bit          exp_valid;
        bit          exp_mread;
        bit          exp_inc;
        logic [31:0] pc_next;

        bus.redirect        = rd;
        bus.redirect_target = tgt;
        bus.mem_ready       = mrdy;
        bus.instr_ready     = irdy;
        #1;
        bus.mem_rdata = memf(bus.mem_addr);
        #1;

        exp_valid = prev_inc || prev_hold;
        exp_mread = !just_reset && !exp_valid;
        exp_inc   = exp_mread && mrdy && !rd && !stale;

        chk("instr_valid", 32'(bus.instr_valid), 32'(exp_valid));
        chk("instr_pc", bus.instr_pc, cur_ipc);
        chk("instr_out", bus.instr_out, cur_out);
        chk("mem_read", 32'(bus.mem_read), 32'(exp_mread));
        if (exp_mread) chk("mem_addr", bus.mem_addr, stale ? stale_addr : pc);
        chk("pc_increment", 32'(bus.pc_increment), 32'(exp_inc));
        chk("pc_load", 32'(bus.pc_load), 32'(rd));
        if (rd) chk("pc_load_value", bus.pc_load_value, tgt);
        chk("pc_step", bus.pc_step, 32'(STEP));

        last_mread = bus.mem_read;
        last_addr  = bus.mem_addr;
        last_valid = bus.instr_valid;
        last_inc   = bus.pc_increment;
        last_ipc   = bus.instr_pc;

        // Program-order delivery to decode
        if (exp_valid && irdy && !rd) begin
            chk("deliver_pc", cur_ipc, exp_pc);
            exp_pc = exp_pc + 32'(STEP);
        end
        if (rd) exp_pc = tgt;

        pc_next = rd ? tgt : (exp_inc ? pc + 32'(STEP) : pc);
        if (exp_inc) begin
            cur_ipc = pc;
            cur_out = memf(pc);
        end
        if (stale) begin
            if (mrdy) stale = 1'b0;
        end else if (exp_mread && !mrdy && rd) begin
            stale      = 1'b1;
            stale_addr = pc;
        end
        prev_inc   = exp_inc;
        prev_hold  = exp_valid && !irdy && !rd;
        just_reset = 1'b0;

        @(posedge clk);
        #1;
        pc        = pc_next;
        bus.pc_in = pc;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        do_reset();

        // Straight-line fetch
        cycle(0, 0, 1, 1);
        chk("first_idle_no_read", 32'(last_mread), 32'd0);
        cycle(0, 0, 1, 1);
        chk("first_read", 32'(last_mread), 32'd1);
        chk("addr0", last_addr, 32'h0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 1);
        chk("addr4", last_addr, 32'h4);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 0);
        chk("addr8", last_addr, 32'h8);

        // Backpressure in VALID
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1, 0);
            chk("bp_valid", 32'(last_valid), 32'd1);
            chk("bp_no_read", 32'(last_mread), 32'd0);
            chk("bp_no_inc", 32'(last_inc), 32'd0);
            chk("bp_ipc", last_ipc, 32'h8);
        end
        cycle(0, 0, 1, 1);
        cycle(0, 0, 1, 1);
        chk("addr_c", last_addr, 32'hC);

        // Redirect in VALID with instr_ready=1
        cycle(1, 32'h100, 1, 1);
        cycle(0, 0, 0, 1);
        chk("redir_valid_dropped", 32'(last_valid), 32'd0);
        chk("redir_target_addr", last_addr, 32'h100);

        // Redirect coincident with mem_ready in REQ
        cycle(1, 32'h8, 1, 1);
        chk("coincident_no_inc", 32'(last_inc), 32'd0);
        cycle(0, 0, 0, 1);
        chk("coincident_next", last_addr, 32'h8);
        chk("coincident_no_valid", 32'(last_valid), 32'd0);

        // Redirect with read outstanding at 0x8, memory answers 2 cycles later
        cycle(1, 32'h200, 0, 1);
        cycle(0, 0, 0, 1);
        chk("drain_hold_addr", last_addr, 32'h8);
        cycle(0, 0, 1, 1);
        chk("drain_done_addr", last_addr, 32'h8);
        chk("drain_discard_inc", 32'(last_inc), 32'd0);
        cycle(0, 0, 1, 1);
        chk("after_drain_addr", last_addr, 32'h200);
        chk("after_drain_no_valid", 32'(last_valid), 32'd0);
        cycle(0, 0, 0, 1);
        chk("after_drain_ipc", last_ipc, 32'h200);

        // Async reset while draining
        cycle(1, 32'h300, 0, 1);
        bus.redirect        = 1'b1;
        bus.redirect_target = 32'h400;
        bus.mem_ready       = 1'b0;
        #1;
        bus.mem_rdata = memf(bus.mem_addr);
        #1;
        chk("pre_rst_drain_read", 32'(bus.mem_read), 32'd1);
        chk("pre_rst_drain_addr", bus.mem_addr, 32'h204);
        rst = 1'b0;
        #1;
        chk("async_mread", 32'(bus.mem_read), 32'd0);
        chk("async_inc", 32'(bus.pc_increment), 32'd0);
        chk("async_load", 32'(bus.pc_load), 32'd0);
        chk("async_valid", 32'(bus.instr_valid), 32'd0);
        chk("async_out", bus.instr_out, 32'd0);
        chk("async_ipc", bus.instr_pc, 32'd0);
        do_reset();
        cycle(0, 0, 1, 1);
        chk("restart_idle", 32'(last_mread), 32'd0);
        cycle(0, 0, 1, 1);
        chk("restart_read", 32'(last_mread), 32'd1);
        chk("restart_addr", last_addr, 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 8) == 0, $urandom & 32'hFFFF_FFFC,
                  ($urandom % 3) != 0, ($urandom % 4) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: STEP, default 4, byte step the fetch unit SHALL request from the program counter per accepted instruction.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  asynchronous, active-low reset.
REQ-004 Port: pc_in  input  int32_t  current program counter value from the PC counter.
REQ-005 Port: pc_increment  output  1  request that the PC counter add pc_step at the next clk edge.
REQ-006 Port: pc_load  output  1  request that the PC counter load pc_load_value at the next clk edge.
REQ-007 Port: pc_step  output  int32_t  constant STEP.
REQ-008 Port: pc_load_value  output  int32_t  redirect target driven to the PC counter.
REQ-009 Port: redirect  input  1  single-cycle branch/jump redirect strobe.
REQ-010 Port: redirect_target  input  int32_t  new PC, valid while redirect=1.
REQ-011 Port: mem_read  output  1  instruction memory read request.
REQ-012 Port: mem_addr  output  int32_t  read address, valid while mem_read=1.
REQ-013 Port: mem_ready  input  1  memory completes the read this cycle and mem_rdata is valid.
REQ-014 Port: mem_rdata  input  int32_t  instruction word.
REQ-015 Port: instr_valid / instr_ready  output / input  1 each  instruction handshake to decode.
REQ-016 Port: instr_out / instr_pc  output  int32_t each  instruction word and its address.

Function
REQ-017 The block SHALL use the states IDLE, REQ, DRAIN and VALID.
REQ-018 IDLE: all strobes are 0, and the block SHALL move to REQ unconditionally.
REQ-019 REQ: mem_read=1 and mem_addr=pc_in (combinational).
- If mem_ready=1 and redirect=0: on the clk edge, instr_out<=mem_rdata and instr_pc<=pc_in; pc_increment=1 in the same cycle; go to VALID.
REQ-020 REQ with mem_ready=0 and redirect=0 SHALL hold state, address and mem_read.
REQ-021 VALID: instr_valid=1, and instr_out/instr_pc SHALL stay stable.
- If instr_ready=1: go to REQ.
- If instr_ready=0: hold state.
REQ-022 In any state, redirect=1 SHALL drive pc_load=1 and pc_load_value=redirect_target that cycle, with pc_increment forced to 0.
- Redirect has priority over increment.
REQ-023 Redirect while in VALID SHALL go to REQ; the held instruction is discarded even if instr_ready=1.
REQ-024 Redirect while in IDLE SHALL go to REQ.
REQ-025 Redirect while in REQ with mem_ready=1 SHALL discard mem_rdata and go to REQ.
REQ-026 Redirect while in REQ with mem_ready=0 SHALL do the following:
- Capture pc_in into an internal drain_addr register.
- Go to DRAIN.
REQ-027 DRAIN: mem_read=1 and mem_addr=drain_addr, so the outstanding request stays stable until completion.
- On mem_ready: discard the data and go to REQ.
REQ-028 A redirect while in DRAIN SHALL reload the PC per REQ-022 and remain in DRAIN, or go to REQ if mem_ready=1 that cycle.
REQ-029 pc_increment and pc_load SHALL never be 1 in the same cycle.
- At most one pc_increment per delivered instruction.
REQ-030 A discarded memory response SHALL never raise instr_valid.
REQ-031 pc_step SHALL equal STEP at all times; addresses are 32-bit and wrap modulo 2^32 in the counter.

Reset
REQ-032 rst=0 SHALL immediately force the following, independent of clk:
- state=IDLE.
- instr_valid=0, instr_out=0, instr_pc=0 and drain_addr=0.
- Combinational outputs mem_read, pc_increment and pc_load=0.
REQ-033 Reset asserted mid-request SHALL abandon the request; instruction memory shares rst and is assumed reset with the block.
REQ-034 After rst rises, the first mem_read SHALL occur in the second clk cycle (IDLE then REQ).

Verification
REQ-035 Straight line: reset, pc_in=0x0, mem_ready=1 each REQ cycle, instr_ready=1 -> mem_addr sequence 0x0, 0x4, 0x8; one pc_increment per instruction; instr_pc matches each address.
REQ-036 Backpressure: instr_ready=0 for 3 cycles in VALID -> instr_out/instr_pc stable, no mem_read, no pc_increment until instr_ready=1.
REQ-037 Redirect in VALID with instr_ready=1, target 0x100 -> pc_load=1 with value 0x100, pc_increment=0, instr_valid drops, next fetch address is 0x100.
REQ-038 Redirect in REQ with mem_ready=0 at address 0x8, memory answers 2 cycles later -> mem_addr held at 0x8 in DRAIN, response discarded (no instr_valid), then fetch at target.
REQ-039 Redirect coincident with mem_ready=1 in REQ -> data discarded, pc_load only, next REQ uses target.
REQ-040 Reset asserted asynchronously in DRAIN -> all outputs 0 before the next clk edge; fetch restarts per REQ-034.
